ctr_ks_gen: RTL

//  Keystream responder for ctr_xor: on each keystream request, drives a 128-bit counter block into
//  the block-cipher engine and returns E(K, CB) on ks_valid/ks_data. Counter uses the GCM inc32 rule.

---
 rtl/ctr_ks_gen.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ctr_ks_gen.sv
// Counter-mode keystream source: issues inc32 counter blocks to a block-cipher engine and hands
// the encrypted blocks to ctr_xor one per ks_req rising edge, optionally keeping one spare block.
module ctr_ks_gen #(
    parameter bit PREFETCH = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ctr_load,
    input  logic [127:0] ctr_init,
    input  logic         ks_req,
    output logic         ks_valid,
    output logic [127:0] ks_data,
    input  logic         ecb_ready,
    output logic         ecb_start,
    output logic [127:0] ecb_block,
    input  logic         ecb_done,
    input  logic [127:0] ecb_result,
    output logic         ctr_wrap
);

    typedef enum logic [1:0] {
        ST_UNLOADED = 2'd0,
        ST_IDLE     = 2'd1,
        ST_BUSY     = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] ctr_q, ctr_d;
    logic         ks_req_q, ks_req_d;
    logic         req_open_q, req_open_d;
    logic         drop_q, drop_d;
    logic         ks_valid_q, ks_valid_d;
    logic [127:0] ks_data_q, ks_data_d;
    logic         spare_valid_q, spare_valid_d;
    logic [127:0] spare_data_q, spare_data_d;
    logic         ecb_start_q, ecb_start_d;
    logic [127:0] ecb_block_q, ecb_block_d;
    logic         ctr_wrap_q, ctr_wrap_d;

    logic         req_edge;
    logic         issue;

    always_comb begin
        state_d       = state_q;
        ctr_d         = ctr_q;
        ks_req_d      = ks_req;
        req_open_d    = req_open_q;
        drop_d        = drop_q;
        ks_valid_d    = ks_valid_q;
        ks_data_d     = ks_data_q;
        spare_valid_d = spare_valid_q;
        spare_data_d  = spare_data_q;
        ecb_start_d   = 1'b0;
        ecb_block_d   = ecb_block_q;
        ctr_wrap_d    = ctr_wrap_q;

        req_edge = ks_req & ~ks_req_q;

        // A new request retires the presented block; it is either served from the spare or left open.
        if (req_edge) begin
            if (spare_valid_q) begin
                ks_valid_d    = 1'b1;
                ks_data_d     = spare_data_q;
                spare_valid_d = 1'b0;
            end else begin
                ks_valid_d = 1'b0;
                req_open_d = 1'b1;
            end
        end

        if (state_q == ST_BUSY && ecb_done) begin
            state_d = ST_IDLE;
            if (drop_q) begin
                drop_d = 1'b0;
            end else if (req_open_d) begin
                ks_valid_d = 1'b1;
                ks_data_d  = ecb_result;
                req_open_d = 1'b0;
            end else begin
                spare_valid_d = 1'b1;
                spare_data_d  = ecb_result;
            end
        end

        // Load flushes every buffered block but keeps outstanding requests against the new counter.
        if (ctr_load) begin
            ctr_d         = ctr_init;
            ks_valid_d    = 1'b0;
            spare_valid_d = 1'b0;
            ctr_wrap_d    = 1'b0;
            req_open_d    = req_open_q | req_edge;
            drop_d        = (state_q == ST_BUSY) && !ecb_done;
            if (state_q == ST_UNLOADED) begin
                state_d = ST_IDLE;
            end
        end

        issue = (state_q == ST_IDLE) && !ctr_load && ecb_ready &&
                (req_open_d || ((PREFETCH != 1'b0) && !spare_valid_d));

        if (issue) begin
            state_d     = ST_BUSY;
            ecb_start_d = 1'b1;
            ecb_block_d = ctr_q;
            ctr_d       = {ctr_q[127:32], ctr_q[31:0] + 32'd1};
            if (&ctr_q[31:0]) begin
                ctr_wrap_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_UNLOADED;
            ctr_q         <= '0;
            ks_req_q      <= 1'b0;
            req_open_q    <= 1'b0;
            drop_q        <= 1'b0;
            ks_valid_q    <= 1'b0;
            ks_data_q     <= '0;
            spare_valid_q <= 1'b0;
            spare_data_q  <= '0;
            ecb_start_q   <= 1'b0;
            ecb_block_q   <= '0;
            ctr_wrap_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            ctr_q         <= ctr_d;
            ks_req_q      <= ks_req_d;
            req_open_q    <= req_open_d;
            drop_q        <= drop_d;
            ks_valid_q    <= ks_valid_d;
            ks_data_q     <= ks_data_d;
            spare_valid_q <= spare_valid_d;
            spare_data_q  <= spare_data_d;
            ecb_start_q   <= ecb_start_d;
            ecb_block_q   <= ecb_block_d;
            ctr_wrap_q    <= ctr_wrap_d;
        end
    end

    assign ks_valid  = ks_valid_q;
    assign ks_data   = ks_data_q;
    assign ecb_start = ecb_start_q;
    assign ecb_block = ecb_block_q;
    assign ctr_wrap  = ctr_wrap_q;

endmodule
